// File: rtl/dmem_ctrl.sv
// Data memory controller: valid/ready request port, registered one-cycle response, RV32I sub-word access,
// fault checks and clear-on-reset. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them.
module dmem_ctrl #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_data,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        busy
);

    localparam int              IDXW      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0]      WAIT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [IDXW-1:0] CLR_LAST  = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [IDXW-1:0]   clr_idx_r;
    logic [3:0]        wait_cnt_r;
    logic              cap_we_r;
    logic [2:0]        cap_funct3_r;
    logic [31:0]       cap_addr_r;
    logic [31:0]       cap_wdata_r;
    logic [31:0]       pend_rdata_r;
    logic              pend_fault_r;
    logic              rsp_valid_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_fault_r;
    logic              busy_r;
    logic [31:0]       mem_r [WORDS];

    logic              fire_s;
    logic              enter_resp_s;
    logic              acc_we_s;
    logic [2:0]        acc_funct3_s;
    logic [31:0]       acc_addr_s;
    logic [31:0]       acc_wdata_s;
    logic              legal_s;
    logic              oob_s;
    logic              misalign_s;
    logic              fault_s;
    logic [1:0]        lane_s;
    logic [IDXW-1:0]   idx_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       shifted_s;
    logic [31:0]       ext_s;
    logic [31:0]       load_data_s;
    logic [3:0]        wmask_s;
    logic [31:0]       wdata_rep_s;
    logic              store_en_s;

    // Next-state logic and handshake/commit strobes.
    always_comb begin
        state_s      = state_r;
        fire_s       = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                if (clr_idx_r == CLR_LAST) state_s = ST_IDLE;
                else                       state_s = ST_CLEAR;
            end
            ST_IDLE: begin
                if (req_valid) begin
                    fire_s = 1'b1;
                    if (LATENCY > 0) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_s      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_CLEAR;
        endcase
    end

    // Access decode; with zero latency the commit edge is the accept edge, so live inputs are used.
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_we_s     = req_we;
            acc_funct3_s = req_funct3;
            acc_addr_s   = req_addr;
            acc_wdata_s  = req_wdata;
        end else begin
            acc_we_s     = cap_we_r;
            acc_funct3_s = cap_funct3_r;
            acc_addr_s   = cap_addr_r;
            acc_wdata_s  = cap_wdata_r;
        end

        case (acc_funct3_s)
            3'b000, 3'b001, 3'b010: legal_s = 1'b1;
            3'b100, 3'b101:         legal_s = !acc_we_s;
            default:                legal_s = 1'b0;
        endcase

        oob_s = ({2'b00, acc_addr_s[31:2]} >= 32'(WORDS));

`ifdef DMEM_MISALIGN_TRAP_EN
        misalign_s = ((acc_funct3_s[1:0] == 2'b01) && acc_addr_s[0]) ||
                     ((acc_funct3_s[1:0] == 2'b10) && (acc_addr_s[1:0] != 2'b00));
        lane_s     = acc_addr_s[1:0];
`else
        misalign_s = 1'b0;
        case (acc_funct3_s[1:0])
            2'b01:   lane_s = {acc_addr_s[1], 1'b0};
            2'b10:   lane_s = 2'b00;
            default: lane_s = acc_addr_s[1:0];
        endcase
`endif

        fault_s   = !legal_s || misalign_s || oob_s;
        idx_s     = acc_addr_s[IDXW+1:2];
        rd_word_s = mem_r[idx_s];
        shifted_s = rd_word_s >> {lane_s, 3'b000};

        case (acc_funct3_s)
            3'b000:  ext_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b001:  ext_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b010:  ext_s = rd_word_s;
            3'b100:  ext_s = {24'h000000, shifted_s[7:0]};
            3'b101:  ext_s = {16'h0000, shifted_s[15:0]};
            default: ext_s = 32'h00000000;
        endcase

        if (fault_s || acc_we_s) load_data_s = 32'h00000000;
        else                     load_data_s = ext_s;

        case (acc_funct3_s[1:0])
            2'b00: begin
                wmask_s     = 4'b0001 << lane_s;
                wdata_rep_s = {4{acc_wdata_s[7:0]}};
            end
            2'b01: begin
                wmask_s     = lane_s[1] ? 4'b1100 : 4'b0011;
                wdata_rep_s = {2{acc_wdata_s[15:0]}};
            end
            2'b10: begin
                wmask_s     = 4'b1111;
                wdata_rep_s = acc_wdata_s;
            end
            default: begin
                wmask_s     = 4'b0000;
                wdata_rep_s = acc_wdata_s;
            end
        endcase

        store_en_s = enter_resp_s && acc_we_s && !fault_s && !rst_data;
    end

    // Control state, request capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst_data) begin
            state_r      <= ST_CLEAR;
            clr_idx_r    <= '0;
            wait_cnt_r   <= 4'd0;
            cap_we_r     <= 1'b0;
            cap_funct3_r <= 3'b000;
            cap_addr_r   <= 32'h00000000;
            cap_wdata_r  <= 32'h00000000;
            pend_rdata_r <= 32'h00000000;
            pend_fault_r <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 32'h00000000;
            rsp_fault_r  <= 1'b0;
            busy_r       <= 1'b1;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_CLEAR);
            if (state_r == ST_CLEAR) begin
                clr_idx_r <= clr_idx_r + 1'b1;
            end
            if (fire_s) begin
                cap_we_r     <= req_we;
                cap_funct3_r <= req_funct3;
                cap_addr_r   <= req_addr;
                cap_wdata_r  <= req_wdata;
                wait_cnt_r   <= 4'd0;
            end else if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end
            if (enter_resp_s) begin
                pend_rdata_r <= load_data_s;
                pend_fault_r <= fault_s;
            end
            // The strobe is launched from RESP so the response lands LATENCY+1 cycles after accept.
            rsp_valid_r <= (state_r == ST_RESP);
            if (state_r == ST_RESP) begin
                rsp_rdata_r <= pend_rdata_r;
                rsp_fault_r <= pend_fault_r;
            end
        end
    end

    // Single write port shared by the clear engine and store commits.
    always_ff @(posedge clk) begin
        if (!rst_data && (state_r == ST_CLEAR)) begin
            mem_r[clr_idx_r] <= 32'h00000000;
        end else if (store_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_s[b]) mem_r[idx_s][8*b +: 8] <= wdata_rep_s[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_fault = rsp_fault_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl (WORDS=256, LATENCY=2): directed requests push expectations, a monitor checks responses.
module tb_dmem_ctrl;

    localparam int WORDS   = 256;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst_data;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        busy;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    dmem_ctrl #(.WORDS(WORDS), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst_data   (rst_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected no response", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
                chk({e.name, "_fault"}, {31'd0, rsp_fault}, {31'd0, e.fault});
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic issue(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input logic ef, input bit push);
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (req_ready !== 1'b1) begin
            checks++;
            $display("FAIL %s_ready_timeout: got req_ready=%b expected 1", name, req_ready);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) sb_q.push_back('{name, er, ef, cyc + LATENCY + 1});
    endtask

    // Called on the first falling edge after the last reset edge.
    task automatic wait_clear(input string name);
        int n = 0;
        bit rdy_bad = 1'b0;
        while (busy === 1'b1 && n < 2000) begin
            if (req_ready !== 1'b0) rdy_bad = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, 32'(n), 32'(WORDS));
        chk({name, "_ready_low_in_clear"}, {31'd0, rdy_bad}, 32'd0);
        chk({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic [31:0] W10_AFTER_SH = 32'hDEAD80EF;
    localparam logic        SH13_FAULT   = 1'b1;
    localparam logic [31:0] LH12         = 32'hFFFFDEAD;
    localparam logic [31:0] LHU12        = 32'h0000DEAD;
    localparam logic [31:0] LH01         = 32'h00000000;
    localparam logic        LH01_FAULT   = 1'b1;
`else
    localparam logic [31:0] W10_AFTER_SH = 32'h123480EF;
    localparam logic        SH13_FAULT   = 1'b0;
    localparam logic [31:0] LH12         = 32'h00001234;
    localparam logic [31:0] LHU12        = 32'h00001234;
    localparam logic [31:0] LH01         = 32'h00005A5A;
    localparam logic        LH01_FAULT   = 1'b0;
`endif

    initial begin
        int n;
        rst_data   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        rst_data = 1'b0;

        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        wait_clear("clear0");

        //    name        we    f3      addr          wdata         exp rdata     exp fault
        issue("lw_3fc",   1'b0, 3'b010, 32'h000003FC, 32'h0,        32'h00000000, 1'b0,       1'b1);
        issue("sw_10",    1'b1, 3'b010, 32'h00000010, 32'hDEADBEEF, 32'h00000000, 1'b0,       1'b1);
        issue("lw_10",    1'b0, 3'b010, 32'h00000010, 32'h0,        32'hDEADBEEF, 1'b0,       1'b1);
        issue("sb_11",    1'b1, 3'b000, 32'h00000011, 32'h00000080, 32'h00000000, 1'b0,       1'b1);
        issue("lb_11",    1'b0, 3'b000, 32'h00000011, 32'h0,        32'hFFFFFF80, 1'b0,       1'b1);
        issue("lbu_11",   1'b0, 3'b100, 32'h00000011, 32'h0,        32'h00000080, 1'b0,       1'b1);
        issue("lw_10b",   1'b0, 3'b010, 32'h00000010, 32'h0,        32'hDEAD80EF, 1'b0,       1'b1);
        issue("sh_13",    1'b1, 3'b001, 32'h00000013, 32'h00001234, 32'h00000000, SH13_FAULT, 1'b1);
        issue("lw_10c",   1'b0, 3'b010, 32'h00000010, 32'h0,        W10_AFTER_SH, 1'b0,       1'b1);
        issue("lh_12",    1'b0, 3'b001, 32'h00000012, 32'h0,        LH12,         1'b0,       1'b1);
        issue("lhu_12",   1'b0, 3'b101, 32'h00000012, 32'h0,        LHU12,        1'b0,       1'b1);
        issue("lw_400",   1'b0, 3'b010, 32'h00000400, 32'h0,        32'h00000000, 1'b1,       1'b1);
        issue("ld_f3_011",1'b0, 3'b011, 32'h00000010, 32'h0,        32'h00000000, 1'b1,       1'b1);
        issue("st_f3_100",1'b1, 3'b100, 32'h00000010, 32'hFFFFFFFF, 32'h00000000, 1'b1,       1'b1);
        issue("lw_10d",   1'b0, 3'b010, 32'h00000010, 32'h0,        W10_AFTER_SH, 1'b0,       1'b1);
        issue("sw_0",     1'b1, 3'b010, 32'h00000000, 32'hA5A55A5A, 32'h00000000, 1'b0,       1'b1);
        issue("lw_0",     1'b0, 3'b010, 32'h00000000, 32'h0,        32'hA5A55A5A, 1'b0,       1'b1);
        issue("lh_2",     1'b0, 3'b001, 32'h00000002, 32'h0,        32'hFFFFA5A5, 1'b0,       1'b1);
        issue("lb_1",     1'b0, 3'b000, 32'h00000001, 32'h0,        32'h0000005A, 1'b0,       1'b1);
        issue("lh_1",     1'b0, 3'b001, 32'h00000001, 32'h0,        LH01,         LH01_FAULT, 1'b1);
        issue("sw_3fc",   1'b1, 3'b010, 32'h000003FC, 32'h11223344, 32'h00000000, 1'b0,       1'b1);
        issue("lbu_3ff",  1'b0, 3'b100, 32'h000003FF, 32'h0,        32'h00000011, 1'b0,       1'b1);

        // Reset lands while the store is still waiting: no response, no commit, clear restarts.
        issue("sw_20_rst",1'b1, 3'b010, 32'h00000020, 32'hCAFEF00D, 32'h00000000, 1'b0,       1'b0);
        @(negedge clk);
        rst_data = 1'b1;
        @(negedge clk);
        rst_data = 1'b0;
        chk("rst2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        wait_clear("clear1");
        issue("lw_20",    1'b0, 3'b010, 32'h00000020, 32'h0,        32'h00000000, 1'b0,       1'b1);
        issue("lw_10e",   1'b0, 3'b010, 32'h00000010, 32'h0,        32'h00000000, 1'b0,       1'b1);

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle word data memory. Adds a valid/ready request port, a single-cycle response pulse and configurable wait-state latency.
- Adds RV32I byte/half/word loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW), bounds and misalignment faults, and a sequential clear-on-reset engine.
- Sits between the load/store unit and on-chip data RAM; it prepares the core for a multi-cycle or pipelined datapath.

Parameters:
- WORDS, 256, number of 32-bit words; legal range 1..65536.
- LATENCY, 1, wait states between request acceptance and the response cycle; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_data  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bytes are used for SB/SH.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  access faulted; qualified by rsp_valid.
- busy  out  1  high while the clear sequence is running.

Behaviour:
- FSM states: CLEAR, IDLE, WAIT, RESP.
- Reset (rst_data=1 at an edge):
  - state <= CLEAR, clear index <= 0, wait counter <= 0.
  - rsp_valid <= 0, rsp_rdata <= 0, rsp_fault <= 0, busy <= 1.
  - req_ready is 0 whenever state != IDLE.
  - Any in-flight request is dropped with no response; a pending store is not committed.
- CLEAR:
  - Writes 0 to mem[index] each cycle and increments index.
  - After mem[WORDS-1] is written, goes to IDLE with busy=0. Total duration is WORDS cycles.
  - Reset asserted during CLEAR restarts the sequence at index 0.
- IDLE:
  - req_ready=1.
  - Handshake fires on an edge where req_valid && req_ready. At that edge the controller captures we, funct3, addr and wdata.
  - Next state is WAIT if LATENCY>0, otherwise RESP.
  - Request inputs are ignored outside IDLE.
- WAIT: counts LATENCY cycles, then goes to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE. There is no back-pressure on the response.
  - Response appears LATENCY+1 cycles after the accepting edge.
  - Maximum throughput is one request per LATENCY+2 cycles.
- Fault checks use the captured fields, in priority order:
  - (1) illegal funct3. Loads allow only 000/001/010/100/101; stores allow only 000/001/010.
  - (2) misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - (3) out of range: addr[31:2] >= WORDS.
  - On a fault: rsp_fault=1, rsp_rdata=0, and memory is unchanged.
- Stores:
  - Commit on the edge that enters RESP, using byte-lane masks from addr[1:0].
  - SB writes one lane, SH writes lanes {1,0} or {3,2}, SW writes all four lanes.
  - Unselected bytes are preserved.
  - Word 0 is writable like any other word.
  - rsp_rdata=0 for all stores.
- Loads:
  - The word is read at that same edge.
  - The lane is selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
  - The result is registered into rsp_rdata.
- Outputs rsp_rdata and rsp_fault hold their values until the next RESP or reset.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: misalignment is checked as above and raises rsp_fault.
- Undefined:
  - No misalignment check is made. Halfword accesses force addr[0]=0 and word accesses force addr[1:0]=0 before lane selection.
  - rsp_fault is raised only for illegal funct3 or out-of-range accesses.

Test Plan:
- Reset with WORDS=256, then hold rst_data=0 -> busy=1 and req_ready=0 for 256 cycles, then busy=0 and req_ready=1; a LW of addr 0x3FC returns 0x00000000.
- LATENCY=2: SW 0xDEADBEEF to 0x10, then LW 0x10 -> rsp_valid pulses exactly 3 cycles after each accept with rdata=0xDEADBEEF and fault=0.
- SB 0x80 to 0x11, then LB 0x11 -> rdata 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
- SH to 0x13 with the macro defined -> fault=1 and the word is unchanged. With the macro undefined, SH 0x1234 to 0x13 writes lanes {3,2}, and LW 0x10 -> 0x123480EF.
- LW 0x400 (index 256 >= WORDS) -> fault=1 and rdata=0; load with funct3=011 -> fault=1.
- Assert rst_data during WAIT of a pending SW -> no rsp_valid pulse and CLEAR restarts; a later LW of that address returns 0.
